line_position_estimator: RTL and testbench
==========================================

Name: line_position_estimator

Overview:
Producer side of the `position` interface consumed by the PID controller. Scans the reflectance-sensor array through the ADC wrapper one channel at a time using a req/ack handshake. Computes the weighted-average line position on the 0..1000 scale, where 500 is centre. Drives the PID `position` input, emits a one-cycle valid pulse per conversion, and applies lost-line saturation.

Parameters:
N_SENS, 5, number of sensor channels; channel 0 is leftmost; 2..8
ADC_W, 10, ADC sample width, unsigned
POS_MAX, 1000, full-scale position; channel i weight = i*POS_MAX/(N_SENS-1), computed at elaboration
LOST_THR, 200, if the sum of all samples is below this, the line is declared lost

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
sample_tick  in  1  start a conversion; only sampled in IDLE
adc_req  out  1  request a sample of channel adc_ch
adc_ch  out  3  channel being requested
adc_ack  in  1  adc_data valid; only meaningful while adc_req=1
adc_data  in  ADC_W  sample value, unsigned
position  out  11  line position 0..POS_MAX, unsigned; feeds the PID `position` input
position_valid  out  1  one-cycle pulse when `position` updates
line_lost  out  1  registered flag; state of the most recent conversion
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset:
  - position=POS_MAX/2 (500), so the PID sees zero error.
  - position_valid=0, line_lost=0, adc_req=0, adc_ch=0, busy=0.
  - Accumulators cleared; state=IDLE.
  - Reset mid-scan or mid-divide aborts the conversion: adc_req is low in the cycle after the reset edge and no valid pulse is issued.
- States: IDLE -> SCAN -> CHECK -> DIV -> OUT -> IDLE.
- IDLE:
  - sample_tick=1 moves to SCAN, with ch=0 and sum=0 and wsum=0.
  - sample_tick in any other state is ignored, not queued.
- SCAN:
  - adc_req=1 and adc_ch=ch. adc_req stays high until adc_ack.
  - On adc_ack: capture adc_data; sum += data; wsum += data*W[ch].
  - If ch==N_SENS-1, go to CHECK; otherwise ch++ and stay in SCAN.
  - adc_ack may arrive in the first request cycle. Each channel costs 1 + (wait cycles) cycles.
- CHECK: compute lost = (sum < LOST_THR), then load the divider with wsum / sum.
  - If sum==0, the divider operands are forced so that no divide-by-zero occurs; lost is necessarily 1.
- DIV:
  - Restoring divider, exactly 11 cycles, one quotient bit per cycle, MSB first.
  - Result is floor(wsum/sum), always ≤ POS_MAX.
  - DIV always runs, including when lost=1, so latency is constant.
- OUT:
  - position_valid=1 for this one cycle.
  - If lost=0: position=quotient.
  - If lost=1: position=0 when the previous position < 500, otherwise POS_MAX. Previous position exactly 500 gives POS_MAX.
  - line_lost=lost.
  - position holds between updates.
- Latency with zero-wait ADC: position_valid is high exactly N_SENS+13 cycles after the cycle in which sample_tick is sampled (18 cycles for N_SENS=5). Every adc_ack wait cycle adds 1 to this.
- Widths, all unsigned:
  - sum: ADC_W+4 bits (max 5115).
  - wsum: ADC_W+12 bits (max 2,557,500).
  - quotient: 11 bits.
  - No overflow is possible at the default parameters. Parameter choices must satisfy (2^ADC_W-1)*POS_MAX*N_SENS/2 < 2^(ADC_W+12).

Decomposition:
- Package line_pkg:
  - POS_MAX, POS_CENTER=500, ADC_W, N_SENS.
  - State enum {IDLE, SCAN, CHECK, DIV, OUT}.
  - Weight-table function.
- One sub-module: seq_divider.
  - Restoring, start/done handshake.
  - Dividend ADC_W+12 bits, divisor ADC_W+4 bits, quotient 11 bits.
  - Fixed 11-cycle run.
  - Reusable later for the motor speed scaling block.

Test Plan:
- Reset: after rst -> position=500, position_valid=0, adc_req=0, busy=0. A tick is held off while rst=1.
- Centre line: ch2=800, others 0, zero-wait ADC -> position=500 and line_lost=0, with valid exactly 18 cycles after the tick.
- Right line: ch3=ch4=600, others 0 -> wsum=1,050,000 and sum=1200 -> position=875.
- Left line, truncation: ch0=1000, ch1=500 -> 125000/1500 -> position=83 (floor).
- Lost line: all channels 10 (sum=50) after a previous position of 875 -> position=1000, line_lost=1. Same stimulus after a previous position of 83 -> position=0. All channels 0 -> no X on position, line_lost=1.
- Handshake and control:
  - ADC ack delayed 3 cycles per channel -> valid at 18+15=33 cycles, and adc_ch is stable while adc_req=1.
  - A tick during busy is ignored: exactly one valid pulse results.
  - rst asserted mid-SCAN -> adc_req is 0 the next cycle, position=500, and no valid pulse.

Source files
------------

// File: rtl/line_pkg.sv
// +--------------------------------------------------------------------+
// | line_pkg: shared constants, FSM states and sensor weight function  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package line_pkg;

  localparam int N_SENS     = 5;
  localparam int ADC_W      = 10;
  localparam int POS_MAX    = 1000;
  localparam int POS_CENTER = 500;
  localparam int LOST_THR   = 200;
  localparam int POS_W      = 11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    CHECK = 3'd2,
    DIV   = 3'd3,
    OUT   = 3'd4
  } state_t;

  // Only ever called with constant arguments, so it folds away at elaboration.
  function automatic int sens_weight(input int idx, input int n_sens, input int pos_max);
    return idx * pos_max / (n_sens - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_divider.sv
// +--------------------------------------------------------------------+
// | seq_divider: restoring divider, one quotient bit per cycle, MSB    |
// | first; requires dividend < 2^Q_W * divisor. Rev 1.0                |
// +--------------------------------------------------------------------+
`default_nettype none

module seq_divider #(
  parameter int DVD_W = 22,
  parameter int DVS_W = 14,
  parameter int Q_W   = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             done,
  output logic [Q_W-1:0]   quotient
);

  localparam int CNT_W = $clog2(Q_W);

  logic [DVS_W-1:0] rem;
  logic [DVS_W-1:0] dvs;
  logic [Q_W-1:0]   low;
  logic [Q_W-2:0]   quo;
  logic [CNT_W-1:0] cnt;
  logic             running;
  logic [DVS_W:0]   trial;
  logic             ge;
  logic [DVS_W-1:0] rem_next;

  always_comb begin
    trial    = {rem, low[Q_W-1]};
    ge       = (trial >= {1'b0, dvs});
    rem_next = ge ? DVS_W'(trial - {1'b0, dvs}) : trial[DVS_W-1:0];
  end

  // Quotient is presented combinationally so it is usable in the done cycle.
  assign quotient = {quo, ge};
  assign done     = running && (cnt == CNT_W'(Q_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      rem     <= '0;
      dvs     <= '0;
      low     <= '0;
      quo     <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      rem     <= DVS_W'(dividend >> Q_W);
      dvs     <= divisor;
      low     <= dividend[Q_W-1:0];
      quo     <= '0;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      rem <= rem_next;
      low <= low << 1;
      quo <= quotient[Q_W-2:0];
      cnt <= cnt + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/line_position_estimator.sv
// +--------------------------------------------------------------------+
// | line_position_estimator: scans the sensor ADC, produces weighted   |
// | line position 0..POS_MAX with lost-line saturation. Rev 1.0        |
// +--------------------------------------------------------------------+
`default_nettype none

module line_position_estimator #(
  parameter int N_SENS   = line_pkg::N_SENS,
  parameter int ADC_W    = line_pkg::ADC_W,
  parameter int POS_MAX  = line_pkg::POS_MAX,
  parameter int LOST_THR = line_pkg::LOST_THR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_tick,
  output logic             adc_req,
  output logic [2:0]       adc_ch,
  input  logic             adc_ack,
  input  logic [ADC_W-1:0] adc_data,
  output logic [10:0]      position,
  output logic             position_valid,
  output logic             line_lost,
  output logic             busy
);

  import line_pkg::*;

  localparam int               SUM_W    = ADC_W + 4;
  localparam int               WSUM_W   = ADC_W + 12;
  localparam logic [2:0]       LAST_CH  = 3'(N_SENS - 1);
  localparam logic [10:0]      POS_FULL = 11'(POS_MAX);
  localparam logic [10:0]      POS_MID  = 11'(POS_MAX / 2);
  localparam logic [SUM_W-1:0] THR      = SUM_W'(LOST_THR);

  state_t             state, state_next;
  logic [2:0]         ch;
  logic [SUM_W-1:0]   sum;
  logic [WSUM_W-1:0]  wsum;
  logic               lost;
  logic               div_start;
  logic               div_done;
  logic [10:0]        quotient;
  logic [SUM_W-1:0]   divisor;
  logic [10:0]        weights [8];

  for (genvar i = 0; i < 8; i++) begin : g_weight
    if (i < N_SENS) begin : g_used
      assign weights[i] = 11'(sens_weight(i, N_SENS, POS_MAX));
    end else begin : g_unused
      assign weights[i] = '0;
    end
  end

  // An all-dark scan leaves wsum at zero, so dividing by one yields zero safely.
  assign divisor = (sum == '0) ? SUM_W'(1) : sum;

  seq_divider #(
    .DVD_W (WSUM_W),
    .DVS_W (SUM_W),
    .Q_W   (11)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (wsum),
    .divisor  (divisor),
    .done     (div_done),
    .quotient (quotient)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next     = state;
    adc_req        = 1'b0;
    adc_ch         = 3'd0;
    busy           = (state != IDLE);
    position_valid = 1'b0;
    div_start      = 1'b0;
    case (state)
      IDLE:  if (sample_tick) state_next = SCAN;
      SCAN: begin
        adc_req = 1'b1;
        adc_ch  = ch;
        if (adc_ack && (ch == LAST_CH)) state_next = CHECK;
      end
      CHECK: begin
        div_start  = 1'b1;
        state_next = DIV;
      end
      DIV:   if (div_done) state_next = OUT;
      OUT: begin
        position_valid = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch        <= 3'd0;
      sum       <= '0;
      wsum      <= '0;
      lost      <= 1'b0;
      position  <= POS_MID;
      line_lost <= 1'b0;
    end else begin
      case (state)
        IDLE: if (sample_tick) begin
          ch   <= 3'd0;
          sum  <= '0;
          wsum <= '0;
        end
        SCAN: if (adc_ack) begin
          sum  <= sum + SUM_W'(adc_data);
          wsum <= wsum + WSUM_W'(adc_data) * WSUM_W'(weights[ch]);
          if (ch != LAST_CH) ch <= ch + 3'd1;
        end
        CHECK: lost <= (sum < THR);
        // Position lands with the last quotient bit so it is valid during OUT.
        DIV: if (div_done) begin
          line_lost <= lost;
          if (!lost)                position <= quotient;
          else if (position < POS_MID) position <= '0;
          else                      position <= POS_FULL;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_line_position_estimator.sv
// +--------------------------------------------------------------------+
// | tb_line_position_estimator: directed table-driven bench            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_line_position_estimator;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_tick;
  logic        adc_req;
  logic [2:0]  adc_ch;
  logic        adc_ack;
  logic [9:0]  adc_data;
  logic [10:0] position;
  logic        position_valid;
  logic        line_lost;
  logic        busy;

  always #5 clk = ~clk;

  line_position_estimator #(
    .N_SENS   (5),
    .ADC_W    (10),
    .POS_MAX  (1000),
    .LOST_THR (200)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sample_tick    (sample_tick),
    .adc_req        (adc_req),
    .adc_ch         (adc_ch),
    .adc_ack        (adc_ack),
    .adc_data       (adc_data),
    .position       (position),
    .position_valid (position_valid),
    .line_lost      (line_lost),
    .busy           (busy)
  );

  typedef struct {
    int    s [5];
    int    wt;
    int    pos;
    int    lost;
    int    lat;
    string name;
  } vec_t;

  vec_t       vecs [9];
  int         checks = 0;
  int         passes = 0;
  logic [9:0] samp [8];
  int         wait_cycles = 0;
  int         ch_glitches = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] actual, input int expected);
    checks++;
    if (actual === 32'(expected)) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic set_vec(input int i, input int s0, input int s1, input int s2,
                         input int s3, input int s4, input int wt, input int pos,
                         input int lost, input int lat, input string nm);
    vecs[i].s[0] = s0; vecs[i].s[1] = s1; vecs[i].s[2] = s2;
    vecs[i].s[3] = s3; vecs[i].s[4] = s4;
    vecs[i].wt = wt; vecs[i].pos = pos; vecs[i].lost = lost;
    vecs[i].lat = lat; vecs[i].name = nm;
  endtask

  // ADC model: answers each request after wait_cycles idle cycles.
  initial begin : adc_model
    int         cnt;
    logic [2:0] held_ch;
    logic       holding;
    cnt = 0; held_ch = 3'd0; holding = 1'b0;
    adc_ack = 1'b0; adc_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (adc_req === 1'b1) begin
        if (holding && adc_ch != held_ch) ch_glitches++;
        if (cnt >= wait_cycles) begin
          adc_ack  = 1'b1;
          adc_data = samp[adc_ch];
          cnt      = 0;
          holding  = 1'b0;
        end else begin
          adc_ack  = 1'b0;
          cnt++;
          holding  = 1'b1;
          held_ch  = adc_ch;
        end
      end else begin
        adc_ack = 1'b0;
        cnt     = 0;
        holding = 1'b0;
      end
    end
  end

  task automatic load_samples(input vec_t v);
    for (int k = 0; k < 8; k++) samp[k] = (k < 5) ? 10'(v.s[k]) : 10'd0;
    wait_cycles = v.wt;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    load_samples(v);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    n = 1;
    while (position_valid !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    check($sformatf("%s_latency", v.name), n, v.lat);
    check($sformatf("%s_position", v.name), position, v.pos);
    check($sformatf("%s_line_lost", v.name), line_lost, v.lost);
    step();
    check($sformatf("%s_pulse_width", v.name), position_valid, 0);
    step();
  endtask

  initial begin : main
    int pulses;
    set_vec(0, 0,    0,   800, 0,   0,   0, 500,  0, 18, "centre");
    set_vec(1, 0,    0,   0,   600, 600, 0, 875,  0, 18, "right");
    set_vec(2, 10,   10,  10,  10,  10,  0, 1000, 1, 18, "lost_after_right");
    set_vec(3, 1000, 500, 0,   0,   0,   0, 83,   0, 18, "left_trunc");
    set_vec(4, 10,   10,  10,  10,  10,  0, 0,    1, 18, "lost_after_left");
    set_vec(5, 0,    0,   0,   0,   0,   0, 0,    1, 18, "all_zero");
    set_vec(6, 0,    0,   800, 0,   0,   3, 500,  0, 33, "centre_wait3");
    set_vec(7, 10,   10,  10,  10,  10,  0, 1000, 1, 18, "lost_after_centre");
    set_vec(8, 1023, 1023, 1023, 1023, 1023, 0, 500, 0, 18, "full_scale");

    for (int k = 0; k < 8; k++) samp[k] = '0;
    rst = 1'b1;
    sample_tick = 1'b1;
    repeat (3) step();
    check("reset_position", position, 500);
    check("reset_valid", position_valid, 0);
    check("reset_adc_req", adc_req, 0);
    check("reset_adc_ch", adc_ch, 0);
    check("reset_busy", busy, 0);
    check("reset_line_lost", line_lost, 0);
    rst = 1'b0;
    sample_tick = 1'b0;
    step();
    check("tick_held_in_reset", busy, 0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);
    check("adc_ch_stable", ch_glitches, 0);

    // Extra ticks in SCAN, DIV and OUT must not start another conversion.
    load_samples(vecs[0]);
    sample_tick = 1'b1;
    step();
    pulses = 0;
    for (int i = 1; i < 60; i++) begin
      if (position_valid === 1'b1) pulses++;
      sample_tick = (i == 3 || i == 10 || i == 17 || i == 18);
      step();
    end
    sample_tick = 1'b0;
    check("tick_while_busy_pulses", pulses, 1);
    check("tick_while_busy_idle", busy, 0);

    // Move position off centre, then abort a scan with reset.
    run_vec(vecs[1]);
    wait_cycles = 3;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    step();
    check("midscan_req_before_rst", adc_req, 1);
    rst = 1'b1;
    step();
    check("midscan_rst_adc_req", adc_req, 0);
    check("midscan_rst_position", position, 500);
    check("midscan_rst_busy", busy, 0);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (position_valid === 1'b1) pulses++;
      step();
    end
    check("midscan_rst_no_valid", pulses, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
